// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: drives the stall/clear pins of every pipeline register.
// Sequences the post-reset flush, load-use and branch hazards, memory freeze and mul/div holds.
module hazard_ctrl #(
    parameter int RESET_FLUSH_CYCLES = 4,
    parameter int MULDIV_LATENCY     = 32
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [4:0]  rs_d,
    input  logic [4:0]  rt_d,
    input  logic        branch_d,
    input  logic        branch_taken_d,
    input  logic        reg_write_e,
    input  logic        mem_to_reg_e,
    input  logic [4:0]  write_reg_e,
    input  logic        mem_to_reg_m,
    input  logic [4:0]  write_reg_m,
    input  logic        muldiv_start_e,
    input  logic        mem_req_m,
    input  logic        mem_ready_m,
    output logic        stall_f,
    output logic        stall_d,
    output logic        stall_e,
    output logic        stall_m,
    output logic        clear_d,
    output logic        clear_e,
    output logic        clear_m,
    output logic        clear_w,
    output logic        muldiv_done,
    output logic [31:0] stall_count
);

    localparam int CNT_MAX = (RESET_FLUSH_CYCLES > MULDIV_LATENCY) ? RESET_FLUSH_CYCLES : MULDIV_LATENCY;
    localparam int CW      = $clog2(CNT_MAX + 1);

    localparam logic [CW-1:0] CNT_RESET = CW'(RESET_FLUSH_CYCLES);
    localparam logic [CW-1:0] CNT_MD    = CW'(MULDIV_LATENCY - 1);

    localparam logic [1:0] ST_FLUSH = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_MD    = 2'd2;

    logic [1:0]    state_reg, state_next;
    logic [CW-1:0] cnt_reg, cnt_next;
    logic [31:0]   stall_count_reg, stall_count_next;

    logic [4:0] src_d [2];
    logic [1:0] hit_e, hit_m;
    logic       match_e, match_m, freeze, lu, br;

    assign src_d[0] = rs_d;
    assign src_d[1] = rt_d;

    // One comparator per ID source operand against each downstream destination.
    for (genvar gi = 0; gi < 2; gi++) begin : g_src_cmp
        assign hit_e[gi] = (write_reg_e == src_d[gi]);
        assign hit_m[gi] = (write_reg_m == src_d[gi]);
    end

    assign match_e = (write_reg_e != 5'd0) & (|hit_e);
    assign match_m = (write_reg_m != 5'd0) & (|hit_m);
    assign freeze  = mem_req_m & ~mem_ready_m;
    assign lu      = mem_to_reg_e & match_e;
    assign br      = branch_d & ((reg_write_e & match_e) | (mem_to_reg_m & match_m));

    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        stall_f     = 1'b0;
        stall_d     = 1'b0;
        stall_e     = 1'b0;
        stall_m     = 1'b0;
        clear_d     = 1'b0;
        clear_e     = 1'b0;
        clear_m     = 1'b0;
        clear_w     = 1'b0;
        muldiv_done = 1'b0;
        case (state_reg)
            ST_FLUSH: begin
                stall_f  = 1'b1;
                clear_d  = 1'b1;
                clear_e  = 1'b1;
                clear_m  = 1'b1;
                clear_w  = 1'b1;
                cnt_next = cnt_reg - CW'(1);
                if (cnt_reg == CW'(1)) state_next = ST_RUN;
            end
            ST_RUN: begin
                if (freeze) begin
                    {stall_f, stall_d, stall_e, stall_m} = 4'b1111;
                    clear_w = 1'b1;
                end else if (muldiv_start_e) begin
                    {stall_f, stall_d, stall_e} = 3'b111;
                    clear_m    = 1'b1;
                    cnt_next   = CNT_MD;
                    state_next = ST_MD;
                end else if (lu | br) begin
                    stall_f = 1'b1;
                    stall_d = 1'b1;
                    clear_e = 1'b1;
                end else if (branch_taken_d) begin
                    clear_d = 1'b1;
                end
            end
            ST_MD: begin
                // A memory freeze suspends the mul/div countdown without consuming latency.
                if (freeze) begin
                    {stall_f, stall_d, stall_e, stall_m} = 4'b1111;
                    clear_w = 1'b1;
                end else if (cnt_reg != '0) begin
                    {stall_f, stall_d, stall_e} = 3'b111;
                    clear_m  = 1'b1;
                    cnt_next = cnt_reg - CW'(1);
                end else begin
                    muldiv_done = 1'b1;
                    state_next  = ST_RUN;
                end
            end
            default: begin
                state_next = ST_FLUSH;
                cnt_next   = CNT_RESET;
            end
        endcase
    end

    assign stall_count_next = stall_count_reg + 32'(stall_f & (state_reg != ST_FLUSH));
    assign stall_count      = stall_count_reg;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg       <= ST_FLUSH;
            cnt_reg         <= CNT_RESET;
            stall_count_reg <= '0;
        end else begin
            state_reg       <= state_next;
            cnt_reg         <= cnt_next;
            stall_count_reg <= stall_count_next;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: expected control vectors are queued per cycle
// and compared against the DUT outputs on the falling edge.
module tb_hazard_ctrl;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [4:0]  rs_d, rt_d, write_reg_e, write_reg_m;
    logic        branch_d, branch_taken_d, reg_write_e, mem_to_reg_e, mem_to_reg_m;
    logic        muldiv_start_e, mem_req_m, mem_ready_m;
    logic        stall_f, stall_d, stall_e, stall_m;
    logic        clear_d, clear_e, clear_m, clear_w, muldiv_done;
    logic [31:0] stall_count;

    // {stall_f, stall_d, stall_e, stall_m, clear_d, clear_e, clear_m, clear_w, muldiv_done}
    localparam logic [8:0] V_FL   = 9'b100011110;
    localparam logic [8:0] V_IDLE = 9'b000000000;
    localparam logic [8:0] V_FRZ  = 9'b111100010;
    localparam logic [8:0] V_MDS  = 9'b111000100;
    localparam logic [8:0] V_HAZ  = 9'b110001000;
    localparam logic [8:0] V_BT   = 9'b000010000;
    localparam logic [8:0] V_DONE = 9'b000000001;

    typedef struct {
        string       tag;
        logic [8:0]  outs;
        logic [31:0] count;
    } exp_t;

    exp_t        sb_q[$];
    int          total  = 0;
    int          passed = 0;
    logic [31:0] exp_sc = 32'd0;

    hazard_ctrl #(.RESET_FLUSH_CYCLES(4), .MULDIV_LATENCY(4)) dut (
        .clock(clock), .reset_n(reset_n),
        .rs_d(rs_d), .rt_d(rt_d),
        .branch_d(branch_d), .branch_taken_d(branch_taken_d),
        .reg_write_e(reg_write_e), .mem_to_reg_e(mem_to_reg_e), .write_reg_e(write_reg_e),
        .mem_to_reg_m(mem_to_reg_m), .write_reg_m(write_reg_m),
        .muldiv_start_e(muldiv_start_e), .mem_req_m(mem_req_m), .mem_ready_m(mem_ready_m),
        .stall_f(stall_f), .stall_d(stall_d), .stall_e(stall_e), .stall_m(stall_m),
        .clear_d(clear_d), .clear_e(clear_e), .clear_m(clear_m), .clear_w(clear_w),
        .muldiv_done(muldiv_done), .stall_count(stall_count)
    );

    always #5 clock = ~clock;

    function automatic logic [8:0] outs_now();
        return {stall_f, stall_d, stall_e, stall_m, clear_d, clear_e, clear_m, clear_w, muldiv_done};
    endfunction

    task automatic check_outs(input string tag, input logic [8:0] obs, input logic [8:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s outs observed=%b expected=%b", tag, obs, exp);
    endtask

    task automatic check_count(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s stall_count observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic idle_inputs();
        rs_d = 5'd1; rt_d = 5'd2; write_reg_e = 5'd0; write_reg_m = 5'd0;
        branch_d = 0; branch_taken_d = 0; reg_write_e = 0; mem_to_reg_e = 0;
        mem_to_reg_m = 0; muldiv_start_e = 0; mem_req_m = 0; mem_ready_m = 1;
    endtask

    // Inputs for this cycle are already driven; queue the expectation, compare at negedge,
    // advance the model's stall counter, then return just after the next rising edge.
    task automatic cyc(input string tag, input logic [8:0] exp, input bit in_flush);
        exp_t e, got;
        e.tag = tag; e.outs = exp; e.count = exp_sc;
        sb_q.push_back(e);
        @(negedge clock);
        got = sb_q.pop_front();
        check_outs(got.tag, outs_now(), got.outs);
        check_count(got.tag, stall_count, got.count);
        $display("cyc %-12s outs=%b count=%h", got.tag, outs_now(), stall_count);
        if (exp[8] && !in_flush) exp_sc = exp_sc + 32'd1;
        @(posedge clock);
        #1;
    endtask

    initial begin
        idle_inputs();
        reset_n = 1'b0;
        #3;
        check_outs("rst_async0", outs_now(), V_FL);
        check_count("rst_async0", stall_count, 32'd0);
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) cyc("flush", V_FL, 1'b1);
        cyc("run_idle", V_IDLE, 1'b0);

        // Load-use, then the same with destination r0.
        mem_to_reg_e = 1; write_reg_e = 5'd5; rt_d = 5'd5;
        cyc("load_use", V_HAZ, 1'b0);
        write_reg_e = 5'd0; rt_d = 5'd0;
        cyc("lu_r0", V_IDLE, 1'b0);
        idle_inputs();

        // Branch compare hazard from a MEM load, with taken in the same cycle.
        branch_d = 1; branch_taken_d = 1; mem_to_reg_m = 1; write_reg_m = 5'd3; rs_d = 5'd3;
        cyc("br_mem_haz", V_HAZ, 1'b0);
        write_reg_m = 5'd7;
        cyc("br_taken", V_BT, 1'b0);
        mem_to_reg_m = 0; branch_taken_d = 0; reg_write_e = 1; write_reg_e = 5'd4; rt_d = 5'd4;
        cyc("br_ex_haz", V_HAZ, 1'b0);
        idle_inputs();

        // Freeze beats a simultaneous load-use; hazard returns once freeze drops.
        mem_to_reg_e = 1; write_reg_e = 5'd6; rs_d = 5'd6; mem_req_m = 1; mem_ready_m = 0;
        cyc("frz_over_lu", V_FRZ, 1'b0);
        mem_ready_m = 1;
        cyc("lu_after_frz", V_HAZ, 1'b0);
        idle_inputs();

        // Mul/div held high; a load-use during MD_WAIT is ignored.
        muldiv_start_e = 1;
        cyc("md_start", V_MDS, 1'b0);
        cyc("md_w3", V_MDS, 1'b0);
        mem_to_reg_e = 1; write_reg_e = 5'd2;
        cyc("md_w2_lu", V_MDS, 1'b0);
        mem_to_reg_e = 0; write_reg_e = 5'd0;
        cyc("md_w1", V_MDS, 1'b0);
        cyc("md_done", V_DONE, 1'b0);
        muldiv_start_e = 0;
        cyc("md_after", V_IDLE, 1'b0);

        // Freeze for 3 cycles mid mul/div: 7 stall cycles in total.
        muldiv_start_e = 1;
        cyc("mdf_start", V_MDS, 1'b0);
        cyc("mdf_w3", V_MDS, 1'b0);
        mem_req_m = 1; mem_ready_m = 0;
        for (int i = 0; i < 3; i++) cyc("mdf_freeze", V_FRZ, 1'b0);
        mem_req_m = 0; mem_ready_m = 1;
        cyc("mdf_w2", V_MDS, 1'b0);
        cyc("mdf_w1", V_MDS, 1'b0);
        cyc("mdf_done", V_DONE, 1'b0);
        muldiv_start_e = 0;
        cyc("mdf_after", V_IDLE, 1'b0);

        // Counter wrap.
        force dut.stall_count_reg = 32'hFFFF_FFFE;
        #1;
        release dut.stall_count_reg;
        exp_sc = 32'hFFFF_FFFE;
        mem_to_reg_e = 1; write_reg_e = 5'd1;
        cyc("wrap_fe", V_HAZ, 1'b0);
        cyc("wrap_ff", V_HAZ, 1'b0);
        idle_inputs();
        cyc("wrap_00", V_IDLE, 1'b0);

        // Async reset in the middle of MD_WAIT.
        muldiv_start_e = 1;
        cyc("mdr_start", V_MDS, 1'b0);
        #2;
        reset_n = 1'b0;
        #1;
        check_outs("rst_mid_md", outs_now(), V_FL);
        check_count("rst_mid_md", stall_count, 32'd0);
        $display("async reset mid MD_WAIT outs=%b count=%h", outs_now(), stall_count);
        exp_sc = 32'd0;
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        idle_inputs();
        for (int i = 0; i < 4; i++) cyc("reflush", V_FL, 1'b1);
        cyc("rerun_idle", V_IDLE, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
